// File: rtl/ysyx_25040111_mtime_rd_pkg.sv
// rtl/ysyx_25040111_mtime_rd_pkg.sv - FSM encoding and default CLINT mtime addresses
// RUNSOC selects the SoC memory map; otherwise the simulation map is used.
package ysyx_25040111_mtime_rd_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AR_HI1 = 3'd1;
  localparam logic [2:0] ST_R_HI1  = 3'd2;
  localparam logic [2:0] ST_AR_LO  = 3'd3;
  localparam logic [2:0] ST_R_LO   = 3'd4;
  localparam logic [2:0] ST_AR_HI2 = 3'd5;
  localparam logic [2:0] ST_R_HI2  = 3'd6;
  localparam logic [2:0] ST_RESP   = 3'd7;

`ifdef RUNSOC
  localparam logic [31:0] MTIME_LO_ADDR = 32'h0200_0048;
  localparam logic [31:0] MTIME_HI_ADDR = 32'h0200_004c;
`else
  localparam logic [31:0] MTIME_LO_ADDR = 32'ha000_0048;
  localparam logic [31:0] MTIME_HI_ADDR = 32'ha000_004c;
`endif

endpackage

// File: rtl/ysyx_25040111_mtime_rd.sv
// rtl/ysyx_25040111_mtime_rd.sv - 64-bit mtime reader over a 32-bit CLINT AR/R channel
// MTIME_RD_CONSIST_EN enables the hi-lo-hi read with retry; otherwise lo-hi with no tear protection.
module ysyx_25040111_mtime_rd
  import ysyx_25040111_mtime_rd_pkg::*;
#(
  parameter logic [31:0] LO_ADDR = MTIME_LO_ADDR,
  parameter logic [31:0] HI_ADDR = MTIME_HI_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  logic [2:0]  state_q, state_d;
  logic        req_ready_q;
  logic [31:0] lo_q, lo_d;
  logic [63:0] resp_data_q, resp_data_d;
`ifdef MTIME_RD_CONSIST_EN
  logic [31:0] hi1_q, hi1_d;
`endif

  // req_ready is registered so it never depends on an input combinationally
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      lo_q        <= '0;
      resp_data_q <= '0;
`ifdef MTIME_RD_CONSIST_EN
      hi1_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      lo_q        <= lo_d;
      resp_data_q <= resp_data_d;
`ifdef MTIME_RD_CONSIST_EN
      hi1_q       <= hi1_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    resp_data_d = resp_data_q;
`ifdef MTIME_RD_CONSIST_EN
    hi1_d       = hi1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
`ifdef MTIME_RD_CONSIST_EN
          state_d = ST_AR_HI1;
`else
          state_d = ST_AR_LO;
`endif
        end
      end
`ifdef MTIME_RD_CONSIST_EN
      ST_AR_HI1: if (arready) state_d = ST_R_HI1;
      ST_R_HI1: begin
        if (rvalid) begin
          hi1_d   = rdata;
          state_d = ST_AR_LO;
        end
      end
`endif
      ST_AR_LO: if (arready) state_d = ST_R_LO;
      ST_R_LO: begin
        if (rvalid) begin
          lo_d    = rdata;
          state_d = ST_AR_HI2;
        end
      end
      ST_AR_HI2: if (arready) state_d = ST_R_HI2;
      ST_R_HI2: begin
        if (rvalid) begin
`ifdef MTIME_RD_CONSIST_EN
          // A changed high half means lo wrapped between reads: re-read lo against the new hi
          if (rdata == hi1_q) begin
            resp_data_d = {hi1_q, lo_q};
            state_d     = ST_RESP;
          end else begin
            hi1_d   = rdata;
            state_d = ST_AR_LO;
          end
`else
          resp_data_d = {rdata, lo_q};
          state_d     = ST_RESP;
`endif
        end
      end
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    resp_valid = 1'b0;
    araddr     = LO_ADDR;
    case (state_q)
      ST_AR_HI1, ST_AR_HI2: begin
        arvalid = 1'b1;
        araddr  = HI_ADDR;
      end
      ST_AR_LO:                     arvalid    = 1'b1;
      ST_R_HI1, ST_R_LO, ST_R_HI2:  rready     = 1'b1;
      ST_RESP:                      resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_ysyx_25040111_mtime_rd.sv
// tb/tb_ysyx_25040111_mtime_rd.sv - scoreboard bench with a scripted CLINT responder
// Expectations follow MTIME_RD_CONSIST_EN the same way the design does.
module tb_ysyx_25040111_mtime_rd;

  localparam logic [31:0] LO_A = 32'ha000_0048;
  localparam logic [31:0] HI_A = 32'ha000_004c;
`ifdef MTIME_RD_CONSIST_EN
  localparam bit CONSIST = 1'b1;
`else
  localparam bit CONSIST = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  ysyx_25040111_mtime_rd #(.LO_ADDR(LO_A), .HI_ADDR(HI_A)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_addr_q[$];
  logic [31:0] rd_data_q[$];
  logic [63:0] exp_resp_q[$];

  int          stall_ar = 0;
  int          stall_r  = 0;
  int          ar_wait  = 0;
  int          r_wait   = 0;
  int          ar_count = 0;
  bit          ar_seen  = 1'b0;
  bit          r_pend   = 1'b0;
  bit          ar_fire  = 1'b0;
  bit          r_fire   = 1'b0;
  logic [31:0] ar_hold  = '0;
  logic [31:0] r_data   = '0;

  // Responder acts on the falling edge; its decisions are what the DUT sees at the next rising edge
  initial begin
    forever begin
      @(negedge clock);
      if (ar_fire) begin
        ar_seen = 1'b0;
        ar_count++;
        if (exp_addr_q.size() == 0) begin
          check("ar_extra", 64'(ar_hold), 64'hffff_ffff_ffff_ffff);
        end else begin
          check("ar_order", 64'(ar_hold), 64'(exp_addr_q.pop_front()));
          r_data = rd_data_q.pop_front();
        end
        r_pend = 1'b1;
        r_wait = stall_r;
      end
      if (r_fire) rvalid = 1'b0;
      if (reset) begin
        arready = 1'b0;
        rvalid  = 1'b0;
        r_pend  = 1'b0;
        ar_seen = 1'b0;
      end else begin
        if (ar_seen) check("arvalid_hold", 64'(arvalid), 64'd1);
        if (arvalid) begin
          if (!ar_seen) begin
            ar_seen = 1'b1;
            ar_hold = araddr;
            ar_wait = stall_ar;
          end else begin
            check("araddr_hold", 64'(araddr), 64'(ar_hold));
          end
          arready = (ar_wait == 0);
          if (ar_wait > 0) ar_wait--;
        end else begin
          ar_seen = 1'b0;
          arready = 1'b0;
        end
        if (r_pend && !rvalid) begin
          if (r_wait == 0) begin
            rvalid = 1'b1;
            rdata  = r_data;
            r_pend = 1'b0;
          end else begin
            r_wait--;
          end
        end
        check("excl", 64'($countones({arvalid, rready, resp_valid}) > 1), 64'd0);
      end
      ar_fire = arvalid && arready && !reset;
      r_fire  = rvalid && rready && !reset;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    rd_data_q.push_back(d);
  endtask

  task automatic push_seq(input logic [31:0] hi, input logic [31:0] lo);
    if (CONSIST) push_rd(HI_A, hi);
    push_rd(LO_A, lo);
    push_rd(HI_A, hi);
  endtask

  task automatic run_req(input logic [63:0] exp, input int sa, input int sr, input int rs);
    int nar;
    int lat;
    int waitc;
    logic [63:0] hold;
    nar      = exp_addr_q.size();
    stall_ar = sa;
    stall_r  = sr;
    ar_count = 0;
    exp_resp_q.push_back(exp);
    req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 500) begin
      tick();
      lat++;
    end
    check("resp_valid_timeout", 64'(resp_valid), 64'd1);
    check("latency", 64'(lat), 64'(1 + nar * (2 + sa + sr)));
    hold = resp_data;
    for (int i = 0; i < rs; i++) begin
      tick();
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", resp_data, hold);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    check("req_ready_busy", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    check("resp_data", resp_data, exp_resp_q.pop_front());
    tick();
    resp_ready = 1'b0;
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
    check("req_ready_rise", 64'(req_ready), 64'd1);
    check("ar_count", 64'(ar_count), 64'(nar));
    check("reads_left", 64'(exp_addr_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    check({tag, "_rready"}, 64'(rready), 64'd0);
    check({tag, "_araddr"}, 64'(araddr), 64'(LO_A));
    check({tag, "_resp_data"}, resp_data, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waitc;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check("post_reset_req_ready", 64'(req_ready), 64'd1);
    check("post_reset_arvalid", 64'(arvalid), 64'd0);
    check("post_reset_rready", 64'(rready), 64'd0);
    check("post_reset_resp_valid", 64'(resp_valid), 64'd0);

    // no carry
    push_seq(32'h0000_0005, 32'h1234_0000);
    run_req(64'h0000_0005_1234_0000, 0, 0, 0);

    // carry between the halves
    if (CONSIST) begin
      push_rd(HI_A, 32'h5);
      push_rd(LO_A, 32'h2);
      push_rd(HI_A, 32'h6);
      push_rd(LO_A, 32'h4);
      push_rd(HI_A, 32'h6);
      run_req(64'h0000_0006_0000_0004, 0, 0, 0);
    end else begin
      push_rd(LO_A, 32'h2);
      push_rd(HI_A, 32'h6);
      run_req(64'h0000_0006_0000_0002, 0, 0, 0);
    end

    // slow responder
    push_seq(32'h0000_0001, 32'habcd_0123);
    run_req(64'h0000_0001_abcd_0123, 3, 4, 0);

    // core stalls the response
    push_seq(32'h0000_0007, 32'h0000_0010);
    run_req(64'h0000_0007_0000_0010, 0, 0, 5);

    // reset while waiting for the low half
    push_seq(32'h0000_0002, 32'h0000_0100);
    stall_ar  = 0;
    stall_r   = 0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    waitc = 0;
    while (!(arvalid && araddr == LO_A) && waitc < 50) begin
      tick();
      waitc++;
    end
    check("reach_ar_lo", 64'(arvalid), 64'd1);
    tick();
    check("in_r_lo", 64'(rready), 64'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    exp_addr_q.delete();
    rd_data_q.delete();

    push_seq(32'hdead_beef, 32'h0000_0001);
    run_req(64'hdead_beef_0000_0001, 0, 0, 0);

    // back-to-back
    for (int i = 0; i < 3; i++) begin
      logic [31:0] hv;
      logic [31:0] lv;
      hv = $urandom;
      lv = $urandom;
      push_seq(hv, lv);
      run_req({hv, lv}, i, 2 - i, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
